// File: rtl/sprite_compositor.sv
// sprite_compositor: merges N sprite pixel streams by fixed priority. Black is
// treated as transparent. The block delays hsync/vsync/blank to line up with
// the sprite pipeline and forces black while blanked. Layers selected by a
// per-frame mask blink with a half-period counted in frames.
module sprite_compositor #(
    parameter int          N_LAYERS     = 4,
    parameter int          PIPE_DELAY   = 2,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                    pixel_clk,
    input  logic                    reset,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    blank_in,
    input  logic [24*N_LAYERS-1:0]  layer_pixels,
    input  logic [N_LAYERS-1:0]     blink_mask,
    output logic [23:0]             pixel_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    blank_out,
    output logic                    blink_phase
);

    // The frame counter must hold BLINK_FRAMES-1 and is never narrower than one bit.
    localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Timing delay line. Stage i holds the input delayed by i+1 cycles.
    // The last stage drives the outputs directly, so the outputs lag the
    // inputs by PIPE_DELAY+1 cycles and line up with the registered pixel.
    // ------------------------------------------------------------------
    logic [PIPE_DELAY:0] hsync_line;
    logic [PIPE_DELAY:0] vsync_line;
    logic [PIPE_DELAY:0] blank_line;
    logic [PIPE_DELAY:0] hsync_next;
    logic [PIPE_DELAY:0] vsync_next;
    logic [PIPE_DELAY:0] blank_next;
    logic                blank_d;

    // With no sprite latency the line is a single register, and the blank
    // that matches the incoming pixels is blank_in itself.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync_next = hsync_in;
            assign vsync_next = vsync_in;
            assign blank_next = blank_in;
            assign blank_d    = blank_in;
        end else begin : g_delay
            assign hsync_next = {hsync_line[PIPE_DELAY-1:0], hsync_in};
            assign vsync_next = {vsync_line[PIPE_DELAY-1:0], vsync_in};
            assign blank_next = {blank_line[PIPE_DELAY-1:0], blank_in};
            assign blank_d    = blank_line[PIPE_DELAY-1];
        end
    endgenerate

    // Shift the timing signals along. Reset fills the line with the idle or
    // blanked level, so the outputs read as blanked until the line refills.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hsync_line <= '1;
            vsync_line <= '1;
            blank_line <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every stage samples its pre-edge neighbour.
            hsync_line <= hsync_next;
            vsync_line <= vsync_next;
            blank_line <= blank_next;
        end
    end

    assign hsync_out = hsync_line[PIPE_DELAY];
    assign vsync_out = vsync_line[PIPE_DELAY];
    assign blank_out = blank_line[PIPE_DELAY];

    // ------------------------------------------------------------------
    // Frame detection and blink control. A frame starts on the falling edge
    // of the raw vsync_in. The blink mask is sampled only at that point, so
    // mid-frame mask changes cannot tear the image.
    // ------------------------------------------------------------------
    logic                vsync_prev;
    logic                frame_start;
    logic [CNT_W-1:0]    frame_cnt;
    logic [N_LAYERS-1:0] mask_shadow;

    assign frame_start = vsync_prev & ~vsync_in;

    // Count frames and toggle the blink phase once per BLINK_FRAMES frame starts.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vsync_prev  <= 1'b1;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            mask_shadow <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (frame_start) begin
                mask_shadow <= blink_mask;
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Composition. A layer is opaque when it is non-black and is not hidden
    // by the blink. The lowest-index opaque layer wins, and blanking
    // overrides everything.
    // ------------------------------------------------------------------
    logic [N_LAYERS-1:0] opaque;
    logic [23:0]         sel_pixel;

    // Find which layers are opaque and pick the highest-priority one.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it holding its old value and no latch is inferred.
        opaque    = '0;
        sel_pixel = BG_COLOR;
        for (int k = 0; k < N_LAYERS; k++) begin
            opaque[k] = (layer_pixels[24*k +: 24] != 24'h000000) &&
                        !(blink_phase && mask_shadow[k]);
        end
        // Walk from the lowest priority to the highest, so the last match is
        // the lowest-index opaque layer.
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (opaque[k]) begin
                sel_pixel = layer_pixels[24*k +: 24];
            end
        end
        if (blank_d) begin
            sel_pixel = 24'h000000;
        end
    end

    // Register the composited pixel, one cycle after layer_pixels.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pixel_out <= 24'h000000;
        end else begin
            pixel_out <= sel_pixel;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed testbench for sprite_compositor. It drives two builds from one
// stimulus set: the main build (4 layers, PIPE_DELAY=2, BLINK_FRAMES=3) and a
// minimal build (1 layer, PIPE_DELAY=0, BLINK_FRAMES=1).
module tb_sprite_compositor;

    localparam logic [23:0] BG1 = 24'h101010;
    localparam logic [23:0] BG2 = 24'h202020;

    logic        pixel_clk;
    logic        reset;
    logic        hsync_in;
    logic        vsync_in;
    logic        blank_in;
    logic [95:0] layers;
    logic [3:0]  mask;
    logic [23:0] layer_s;
    logic        mask_s;

    logic [23:0] pix1;
    logic        hs1, vs1, bl1, ph1;
    logic [23:0] pix2;
    logic        hs2, vs2, bl2, ph2;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_compositor #(
        .N_LAYERS(4), .PIPE_DELAY(2), .BG_COLOR(BG1), .BLINK_FRAMES(3)
    ) dut (
        .pixel_clk(pixel_clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .layer_pixels(layers), .blink_mask(mask),
        .pixel_out(pix1), .hsync_out(hs1), .vsync_out(vs1),
        .blank_out(bl1), .blink_phase(ph1)
    );

    sprite_compositor #(
        .N_LAYERS(1), .PIPE_DELAY(0), .BG_COLOR(BG2), .BLINK_FRAMES(1)
    ) dut_small (
        .pixel_clk(pixel_clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .layer_pixels(layer_s), .blink_mask(mask_s),
        .pixel_out(pix2), .hsync_out(hs2), .vsync_out(vs2),
        .blank_out(bl2), .blink_phase(ph2)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Watchdog: the run uses fixed cycle counts, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // One vsync falling edge, followed by one cycle high.
    task automatic vsync_pulse();
        vsync_in = 1'b0;
        tick();
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        blank_in = 1'b0;
        layers   = '0;
        mask     = '0;
        layer_s  = '0;
        mask_s   = 1'b0;
        #3;
        n_checks++; if (pix1 !== 24'h000000) $display("FAIL reset_pixel: got %h want 000000", pix1); else n_pass++;
        n_checks++; if ({hs1, vs1, bl1} !== 3'b111) $display("FAIL reset_timing: got %b want 111", {hs1, vs1, bl1}); else n_pass++;
        n_checks++; if (ph1 !== 1'b0) $display("FAIL reset_phase: got %b want 0", ph1); else n_pass++;
        tick();
        tick();
        #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_priority();
        layers = {24'h000000, 24'h00FF00, 24'hFF8000, 24'h000000};
        tick();
        n_checks++; if (pix1 !== 24'hFF8000) $display("FAIL prio_layer1: got %h want FF8000", pix1); else n_pass++;
        layers[23:0] = 24'h0000FF;
        tick();
        n_checks++; if (pix1 !== 24'h0000FF) $display("FAIL prio_layer0: got %h want 0000FF", pix1); else n_pass++;
        layers = {24'h000000, 24'h00FF00, 24'h000000, 24'h000000};
        tick();
        n_checks++; if (pix1 !== 24'h00FF00) $display("FAIL prio_layer2: got %h want 00FF00", pix1); else n_pass++;
        layers = '0;
        tick();
        n_checks++; if (pix1 !== BG1) $display("FAIL prio_bg: got %h want %h", pix1, BG1); else n_pass++;
    endtask

    task automatic test_blank_align();
        logic        exp_hs;
        logic        exp_bl;
        logic [23:0] exp_pix;
        layers = {24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000};
        // Cycle 0: hsync low for one cycle; blank high for cycles 0..5.
        hsync_in = 1'b0;
        blank_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) hsync_in = 1'b1;
            if (k == 6) blank_in = 1'b0;
            exp_hs  = (k == 3) ? 1'b0 : 1'b1;
            exp_bl  = (k >= 3 && k <= 8);
            exp_pix = exp_bl ? 24'h000000 : 24'hFFFFFF;
            n_checks++; if (hs1 !== exp_hs) $display("FAIL align_hsync k=%0d: got %b want %b", k, hs1, exp_hs); else n_pass++;
            n_checks++; if (bl1 !== exp_bl) $display("FAIL align_blank k=%0d: got %b want %b", k, bl1, exp_bl); else n_pass++;
            n_checks++; if (pix1 !== exp_pix) $display("FAIL align_pixel k=%0d: got %h want %h", k, pix1, exp_pix); else n_pass++;
        end
    endtask

    task automatic test_blink();
        logic        exp_ph;
        logic [23:0] exp_pix;
        mask   = 4'b0010;
        layers = {24'h000000, 24'h000000, 24'h123456, 24'h000000};
        tick();
        n_checks++; if (pix1 !== 24'h123456) $display("FAIL blink_start: got %h want 123456", pix1); else n_pass++;
        for (int e = 1; e <= 7; e++) begin
            vsync_pulse();
            exp_ph  = ((e / 3) % 2) == 1;
            exp_pix = exp_ph ? BG1 : 24'h123456;
            n_checks++; if (ph1 !== exp_ph) $display("FAIL blink_phase e=%0d: got %b want %b", e, ph1, exp_ph); else n_pass++;
            n_checks++; if (pix1 !== exp_pix) $display("FAIL blink_pixel e=%0d: got %h want %h", e, pix1, exp_pix); else n_pass++;
        end
    endtask

    task automatic test_mask_change();
        // Counter sits at 1 after seven edges; two more edges reach phase 1.
        vsync_pulse();
        vsync_pulse();
        n_checks++; if (ph1 !== 1'b1) $display("FAIL mask_phase: got %b want 1", ph1); else n_pass++;
        n_checks++; if (pix1 !== BG1) $display("FAIL mask_hidden: got %h want %h", pix1, BG1); else n_pass++;
        mask = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (pix1 !== BG1) $display("FAIL mask_midframe: got %h want %h", pix1, BG1); else n_pass++;
        vsync_pulse();
        n_checks++; if (pix1 !== 24'h123456) $display("FAIL mask_next_frame: got %h want 123456", pix1); else n_pass++;
        n_checks++; if (ph1 !== 1'b1) $display("FAIL mask_phase_kept: got %b want 1", ph1); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic exp_idle;
        hsync_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if ({hs1, bl1, pix1} !== {1'b0, 1'b0, 24'h123456}) $display("FAIL pre_reset: got %b %b %h want 0 0 123456", hs1, bl1, pix1); else n_pass++;
        @(posedge pixel_clk);
        #3 reset = 1'b1;
        #1;
        n_checks++; if (pix1 !== 24'h000000) $display("FAIL async_pixel: got %h want 000000", pix1); else n_pass++;
        n_checks++; if ({hs1, vs1, bl1} !== 3'b111) $display("FAIL async_timing: got %b want 111", {hs1, vs1, bl1}); else n_pass++;
        n_checks++; if (ph1 !== 1'b0) $display("FAIL async_phase: got %b want 0", ph1); else n_pass++;
        @(posedge pixel_clk);
        #3 reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_idle = (k < 3);
            n_checks++; if (hs1 !== exp_idle) $display("FAIL refill_hsync k=%0d: got %b want %b", k, hs1, exp_idle); else n_pass++;
            n_checks++; if (bl1 !== exp_idle) $display("FAIL refill_blank k=%0d: got %b want %b", k, bl1, exp_idle); else n_pass++;
            n_checks++; if (pix1 !== (exp_idle ? 24'h000000 : 24'h123456)) $display("FAIL refill_pixel k=%0d: got %h", k, pix1); else n_pass++;
        end
        n_checks++; if (ph1 !== 1'b0) $display("FAIL refill_phase: got %b want 0", ph1); else n_pass++;
        hsync_in = 1'b1;
        tick();
    endtask

    task automatic test_small_config();
        hsync_in = 1'b0;
        tick();
        n_checks++; if (hs2 !== 1'b0) $display("FAIL small_hsync_low: got %b want 0", hs2); else n_pass++;
        hsync_in = 1'b1;
        tick();
        n_checks++; if (hs2 !== 1'b1) $display("FAIL small_hsync_high: got %b want 1", hs2); else n_pass++;
        layer_s = 24'hABCDEF;
        tick();
        n_checks++; if (pix2 !== 24'hABCDEF) $display("FAIL small_pixel: got %h want ABCDEF", pix2); else n_pass++;
        layer_s = 24'h000000;
        tick();
        n_checks++; if (pix2 !== BG2) $display("FAIL small_bg: got %h want %h", pix2, BG2); else n_pass++;
        blank_in = 1'b1;
        layer_s  = 24'hABCDEF;
        tick();
        n_checks++; if ({bl2, pix2} !== {1'b1, 24'h000000}) $display("FAIL small_blank: got %b %h want 1 000000", bl2, pix2); else n_pass++;
        blank_in = 1'b0;
        mask_s   = 1'b1;
        tick();
        // One frame per half-period: every frame start toggles the phase.
        vsync_pulse();
        n_checks++; if ({ph2, pix2} !== {1'b1, BG2}) $display("FAIL small_blink_on: got %b %h want 1 %h", ph2, pix2, BG2); else n_pass++;
        vsync_pulse();
        n_checks++; if ({ph2, pix2} !== {1'b0, 24'hABCDEF}) $display("FAIL small_blink_off: got %b %h want 0 ABCDEF", ph2, pix2); else n_pass++;
        // vsync held low yields a single frame start.
        vsync_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (ph2 !== 1'b1) $display("FAIL small_vsync_held: got %b want 1", ph2); else n_pass++;
        vsync_in = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_blank_align();
        test_blink();
        test_mask_change();
        test_async_reset();
        test_small_config();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
